viterbi_decoder_k4: RTL

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-4 convolutional code produced by our K=4 encoder. It accepts one 2-bit code symbol per `in_valid` cycle and runs an 8-state add-compare-select. It keeps survivors by register exchange. After a fixed decision depth it emits one decoded bit per accepted symbol. It sits at the receive end of the encoder/channel path and is the counterpart block for the encoder-decoder bench.

---
 rtl/conv_k4_pkg.sv | 21 ++
 rtl/viterbi_acs_k4.sv | 30 +++
 rtl/viterbi_decoder_k4.sv | 126 ++++++++++++
 3 files changed

// File: rtl/conv_k4_pkg.sv
// rtl/conv_k4_pkg.sv - shared definitions for the K=4 rate-1/2 convolutional code
package conv_k4_pkg;

    localparam int K          = 4;
    localparam int NUM_STATES = 8;

    // Generator taps over {u, d1, d2, d3}
    localparam logic [3:0] G1 = 4'b1111;
    localparam logic [3:0] G0 = 4'b1101;

    // Encoder state {d1, d2, d3}, d1 is the most recent past input bit
    typedef logic [2:0] state_t;

    // Code symbol {c1, c0} emitted when input u is applied in encoder state 'state'
    function automatic logic [1:0] expected_symbol(input state_t state, input logic u);
        logic [3:0] reg_bits;
        reg_bits = {u, state};
        return {^(reg_bits & G1), ^(reg_bits & G0)};
    endfunction

endpackage

// File: rtl/viterbi_acs_k4.sv
// rtl/viterbi_acs_k4.sv - one add-compare-select unit with saturating adds
module viterbi_acs_k4 #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm_pred0,
    input  logic [PM_W-1:0] pm_pred1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_out,
    output logic            dec
);

    localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    // Saturating add per candidate, then pick the smaller; a tie keeps the d3=0 predecessor
    always_comb begin
        sum0   = {1'b0, pm_pred0} + {{(PM_W-1){1'b0}}, bm0};
        sum1   = {1'b0, pm_pred1} + {{(PM_W-1){1'b0}}, bm1};
        cand0  = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
        cand1  = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
        dec    = (cand1 < cand0);
        pm_out = dec ? cand1 : cand0;
    end

endmodule

// File: rtl/viterbi_decoder_k4.sv
// rtl/viterbi_decoder_k4.sv - hard-decision register-exchange Viterbi decoder, K=4 rate 1/2
module viterbi_decoder_k4
    import conv_k4_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] encoded_bits,
    input  logic       in_valid,
    output logic       out,
    output logic       out_valid
);

    localparam int              CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TB_DEPTH);
    localparam logic [PM_W-1:0]  PM_INIT = PM_W'(8);

    logic [PM_W-1:0]     pm_q     [NUM_STATES];
    logic [PM_W-1:0]     pm_d     [NUM_STATES];
    logic [TB_DEPTH-1:0] path_q   [NUM_STATES];
    logic [TB_DEPTH-1:0] path_d   [NUM_STATES];
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                out_q;
    logic                out_d;
    logic                out_valid_q;
    logic                out_valid_d;

    logic [1:0]          bm0      [NUM_STATES];
    logic [1:0]          bm1      [NUM_STATES];
    logic [PM_W-1:0]     pm_acs   [NUM_STATES];
    logic                dec      [NUM_STATES];
    logic [TB_DEPTH-1:0] path_new [NUM_STATES];

    logic [PM_W-1:0]     pm_min;
    state_t              best;
    logic [CNT_W-1:0]    count_next;

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
    endfunction

    // Next state n = {u, a, b} is reached from {a, b, 0} and {a, b, 1}
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_state
        localparam int   P0    = (n % 4) * 2;
        localparam int   P1    = P0 + 1;
        localparam logic U_BIT = (n >= 4);

        assign bm0[n] = hamming2(encoded_bits, expected_symbol(state_t'(P0), U_BIT));
        assign bm1[n] = hamming2(encoded_bits, expected_symbol(state_t'(P1), U_BIT));

        viterbi_acs_k4 #(
            .PM_W (PM_W)
        ) u_acs (
            .pm_pred0 (pm_q[P0]),
            .pm_pred1 (pm_q[P1]),
            .bm0      (bm0[n]),
            .bm1      (bm1[n]),
            .pm_out   (pm_acs[n]),
            .dec      (dec[n])
        );

        assign path_new[n] = dec[n] ? {path_q[P1][TB_DEPTH-2:0], U_BIT}
                                    : {path_q[P0][TB_DEPTH-2:0], U_BIT};
    end

    // Best state and minimum metric in one scan; strict compare keeps the lowest index on ties
    always_comb begin
        pm_min = pm_acs[0];
        best   = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_acs[i] < pm_min) begin
                pm_min = pm_acs[i];
                best   = state_t'(i);
            end
        end
    end

    // Normalize, exchange survivors, count symbols and form the decision when a symbol is accepted
    always_comb begin
        count_next  = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_d[i]   = pm_q[i];
            path_d[i] = path_q[i];
        end
        if (in_valid) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_d[i]   = pm_acs[i] - pm_min;
                path_d[i] = path_new[i];
            end
            count_d     = count_next;
            out_d       = path_new[best][TB_DEPTH-1];
            out_valid_d = (count_next >= DEPTH_C);
        end
    end

    // State registers; reset biases the metrics toward the all-zero encoder state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
                path_q[i] <= '0;
            end
            count_q     <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= pm_d[i];
                path_q[i] <= path_d[i];
            end
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
